square_wave_meter_mc: RTL and testbench
=======================================

# square_wave_meter_mc

Multi-channel, parametrised successor to the single-channel equal-precision square-wave frequency meter. Each channel synchronises its input, waits for a rising edge, then counts `sys_clk` cycles across exactly N input periods: total cycles and high-level cycles, for frequency and duty. Channels run independently. Finished results are delivered one at a time on a shared valid/ready result port, chosen by a round-robin arbiter. The block sits between the PLL-clocked capture front end and the MCU register interface.

## Interface
- `CH_NUM`, 4: number of input channels, 1..16.
- `CNT_W`, 32: width of the period and high-time counters.
- `N_W`, 16: width of the period-count request.
- `TIMEOUT_CYC`, 200_000_000: window cycle limit (1 s at 200 MHz); must fit in `CNT_W` bits.
- `sys_clk`  in  1  measurement clock (PLL, 200 MHz). One clock; reset is asynchronous and active-high.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `wave_in`  in  CH_NUM  asynchronous square-wave inputs.
- `start`  in  CH_NUM  per-channel one-cycle start pulse.
- `N`  in  N_W  number of periods to measure, sampled at start.
- `busy`  out  CH_NUM  channel not in IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_ch`  out  $clog2(CH_NUM) (min 1)  channel of the result.
- `res_period`  out  CNT_W  cycles spanned by N periods.
- `res_high`  out  CNT_W  cycles `wave_in` was high inside the window.
- `res_timeout`  out  1  window aborted by timeout; counts valid up to the abort.

## Operation
- Input path per channel: 2-flop synchroniser, then a delay flop. `rise = sync & ~dly`.
- Per-channel FSM:
  - IDLE: a `start` pulse latches `n_lat = (N==0) ? 1 : N`, clears the counters and moves to ARM.
  - ARM: waits for `rise`. `wait_cnt` increments each cycle; reaching TIMEOUT_CYC goes to DONE with timeout=1, period=0, high=0. On `rise`: `period_cnt=1`, `high_cnt=1`, `edge_cnt=0`, go to MEAS.
  - MEAS: `period_cnt` increments each cycle, and `high_cnt` increments each cycle `sync==1`.
    - On `rise`, `edge_cnt` increments. When `edge_cnt+1 == n_lat`, go to DONE with the counts as of the previous cycle. The Nth edge cycle is not counted, so the window is exactly N periods.
    - When `period_cnt` reaches TIMEOUT_CYC, go to DONE with timeout=1.
  - DONE: holds the result until granted by the arbiter, then returns to IDLE.
- `start` is ignored when the channel is not IDLE. `N` changes do not affect a running window.
- Arbiter:
  - Round-robin over channels in DONE. The pointer starts after the last granted channel; after reset it starts at channel 0.
  - The output register loads the granted channel's result. Grant happens only when the output register is empty, or is being emptied the same cycle (`res_valid & res_ready`). This allows back-to-back delivery at one result per cycle.
- Arithmetic: counters are unsigned and cannot wrap, because timeout fires first. `edge_cnt` is N_W bits.

## Timing
- Reset: all FSMs IDLE, counters 0, `busy=0`, `res_valid=0`, `res_ch=0`, `res_period=0`, `res_high=0`, `res_timeout=0`, arbiter pointer 0.
- Input-to-`rise` latency: 2–3 cycles, depending on the phase of the edge. It is identical for every edge, so it cancels out of the counts.
- Start to `busy=1`: 1 cycle.
- Nth `rise` to DONE: 1 cycle. DONE to `res_valid=1`: 1 cycle if the port is free.
- `res_*` hold stable while `res_valid & ~res_ready`. `res_valid` drops the cycle after acceptance unless another result is loaded.
- Simultaneous DONE on several channels: one channel is granted per cycle in round-robin order. No result is lost.
- A `start` in the same cycle the channel returns to IDLE is ignored. Start is accepted only while in IDLE.
- Reset asserted mid-window or while holding a result: everything clears at once and the pending result is discarded.

## Test plan
- Ch0 with period 20 cycles and high 5, N=100, `res_ready=1` → one result: ch=0, period=2000, high=500, timeout=0.
- N=0 on ch1 with period 37 and high 20 → treated as N=1: period=37, high=20.
- All 4 channels started together with identical 10-cycle waves and N=4, `res_ready=0` for 50 cycles then 1 → four results in order ch0, ch1, ch2, ch3 on consecutive cycles. Each has period=40, and `res_*` are stable while stalled.
- Ch2 input held at 0 with TIMEOUT_CYC=1000 → after ~1000 cycles: ch=2, timeout=1, period=0, high=0.
- Ch3 input held high after a single rising edge, TIMEOUT_CYC=1000 → timeout=1, period=1000, high=1000.
- `sys_rst` pulsed mid-window on ch0, then restarted with period 16 and N=8 → no stale result appears. The new result has period=128.

Source files
------------

// File: rtl/square_wave_meter_mc_if.sv
// square_wave_meter_mc_if: result port of the multi-channel square-wave meter.
// Signals:
//   valid   - a result is held on the port
//   ready   - consumer accepts the held result this cycle
//   ch      - channel that produced the result
//   period  - sys_clk cycles spanned by the N measured periods
//   high    - sys_clk cycles the input was high inside the window
//   timeout - window aborted by the cycle limit; counts valid up to the abort
// Modports: master (meter side), slave (consumer side).
interface square_wave_meter_mc_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    logic             valid;
    logic             ready;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             timeout;

    modport master (output valid, ch, period, high, timeout, input ready);
    modport slave  (input valid, ch, period, high, timeout, output ready);
endinterface

// File: rtl/square_wave_meter_mc.sv
// square_wave_meter_mc: multi-channel equal-precision square-wave period/duty meter.
// Ports:
//   sys_clk  - measurement clock
//   sys_rst  - asynchronous active-high reset
//   wave_in  - per-channel asynchronous square-wave inputs
//   start    - per-channel one-cycle start pulse (honoured only while idle)
//   N        - number of periods to measure, sampled at start (0 acts as 1)
//   busy     - per-channel "not idle"
//   res      - round-robin arbitrated valid/ready result port (master side)
module square_wave_meter_mc #(
    parameter int          CH_NUM      = 4,
    parameter int          CNT_W       = 32,
    parameter int          N_W         = 16,
    parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [CH_NUM-1:0]   wave_in,
    input  logic [CH_NUM-1:0]   start,
    input  logic [N_W-1:0]      N,
    output logic [CH_NUM-1:0]   busy,
    square_wave_meter_mc_if.master res
);
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    logic [CH_NUM-1:0] req;
    logic [CH_NUM-1:0] tmo_q;
    logic [CNT_W-1:0]  per_q  [CH_NUM];
    logic [CNT_W-1:0]  high_q [CH_NUM];
    logic              can_load;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   rr_ptr;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic             meta, sync, dly, rise, gnt;
        state_t           st, st_nx;
        logic [CNT_W-1:0] per, per_nx, high, high_nx, wait_cnt, wait_nx;
        logic [N_W-1:0]   edge_cnt, edge_nx, n_lat, n_nx;
        logic             tmo, tmo_nx;

        // The synchroniser latency is the same for every edge, so it cancels
        // out of both counts.
        assign rise = sync & ~dly;
        assign gnt  = gnt_vld && (gnt_idx == CH_W'(c));

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                meta     <= 1'b0;
                sync     <= 1'b0;
                dly      <= 1'b0;
                st       <= IDLE;
                per      <= '0;
                high     <= '0;
                wait_cnt <= '0;
                edge_cnt <= '0;
                n_lat    <= '0;
                tmo      <= 1'b0;
            end else begin
                meta     <= wave_in[c];
                sync     <= meta;
                dly      <= sync;
                st       <= st_nx;
                per      <= per_nx;
                high     <= high_nx;
                wait_cnt <= wait_nx;
                edge_cnt <= edge_nx;
                n_lat    <= n_nx;
                tmo      <= tmo_nx;
            end
        end

        always_comb begin
            st_nx   = st;
            per_nx  = per;
            high_nx = high;
            wait_nx = wait_cnt;
            edge_nx = edge_cnt;
            n_nx    = n_lat;
            tmo_nx  = tmo;
            case (st)
                IDLE: if (start[c]) begin
                    st_nx   = ARM;
                    n_nx    = (N == '0) ? N_W'(1) : N;
                    per_nx  = '0;
                    high_nx = '0;
                    wait_nx = '0;
                    edge_nx = '0;
                    tmo_nx  = 1'b0;
                end
                ARM: if (rise) begin
                    // The first edge cycle is the first cycle of the window
                    // and the input is high in it.
                    st_nx   = MEAS;
                    per_nx  = CNT_W'(1);
                    high_nx = CNT_W'(1);
                    edge_nx = '0;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                    if (wait_nx == TO_LIM) begin
                        st_nx   = DONE;
                        tmo_nx  = 1'b1;
                        per_nx  = '0;
                        high_nx = '0;
                    end
                end
                MEAS: if (rise && (edge_cnt + 1'b1 == n_lat)) begin
                    // The closing edge belongs to the next period: leave the
                    // counts untouched so the window is exactly N periods.
                    st_nx = DONE;
                end else begin
                    per_nx  = per + 1'b1;
                    high_nx = high + CNT_W'(sync);
                    edge_nx = edge_cnt + N_W'(rise);
                    if (per_nx == TO_LIM) begin
                        st_nx  = DONE;
                        tmo_nx = 1'b1;
                    end
                end
                DONE: if (gnt) st_nx = IDLE;
                default: st_nx = IDLE;
            endcase
        end

        assign busy[c]   = (st != IDLE);
        assign req[c]    = (st == DONE);
        assign tmo_q[c]  = tmo;
        assign per_q[c]  = per;
        assign high_q[c] = high;
    end

    // Loading is allowed when the port is empty or drains this cycle, which
    // gives one result per cycle when several channels finish together.
    assign can_load = ~res.valid | res.ready;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] p, input int k);
        int j = int'(p) + k;
        return CH_W'((j >= CH_NUM) ? j - CH_NUM : j);
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!gnt_vld && can_load && req[rr_idx(rr_ptr, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx(rr_ptr, k);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            res.valid   <= 1'b0;
            res.ch      <= '0;
            res.period  <= '0;
            res.high    <= '0;
            res.timeout <= 1'b0;
            rr_ptr      <= '0;
        end else if (gnt_vld) begin
            res.valid   <= 1'b1;
            res.ch      <= gnt_idx;
            res.period  <= per_q[gnt_idx];
            res.high    <= high_q[gnt_idx];
            res.timeout <= tmo_q[gnt_idx];
            rr_ptr      <= (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (res.ready) begin
            res.valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_square_wave_meter_mc.sv
// tb_square_wave_meter_mc: self-checking bench for square_wave_meter_mc.
// Waveforms are described as lists of (period, high) segments; the expected
// counts are the sums of the segments inside the measurement window.
module tb_square_wave_meter_mc;
    localparam int CH = 4;
    localparam int TO = 2500;
    localparam int MAXSEG = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wave_in;
    logic [3:0]  start;
    logic [3:0]  busy;
    logic [15:0] n_in;

    square_wave_meter_mc_if #(.CH_W(2), .CNT_W(32)) rif ();

    square_wave_meter_mc #(
        .CH_NUM(CH), .CNT_W(32), .N_W(16), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .wave_in(wave_in),
        .start(start),
        .N(n_in),
        .busy(busy),
        .res(rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint per;
        longint hi;
        int     tmo;
        longint cyc;
    } res_t;

    typedef struct {
        int     ch;
        int     kind;   // 0 periodic, 1 held low, 2 held high after one edge
        int     p;
        int     h;
        int     n;
        longint ep;
        longint eh;
        int     et;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    res_t   rq[$];

    int sp [CH][MAXSEG];
    int sh [CH][MAXSEG];
    int nseg [CH];
    int ld_cnt [CH];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int si [CH];
        int pos [CH];
        int last [CH];
        for (int c = 0; c < CH; c++) begin
            si[c] = 0;
            pos[c] = 0;
            last[c] = 0;
        end
        wave_in = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < CH; c++) begin
                if (last[c] != ld_cnt[c]) begin
                    last[c] = ld_cnt[c];
                    si[c] = 0;
                    pos[c] = 0;
                end
                if (si[c] < nseg[c]) begin
                    wave_in[c] = pos[c] < sh[c][si[c]];
                    pos[c]++;
                    if (pos[c] >= sp[c][si[c]]) begin
                        pos[c] = 0;
                        si[c]++;
                    end
                end else begin
                    wave_in[c] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rif.valid && rif.ready) begin
            res_t r;
            r.ch  = int'(rif.ch);
            r.per = longint'(rif.period);
            r.hi  = longint'(rif.high);
            r.tmo = int'(rif.timeout);
            r.cyc = cyc;
            rq.push_back(r);
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Leading low gap, then cnt identical (p, h) periods.
    task automatic load_seg(input int c, input int gap, input int p, input int h, input int cnt);
        sp[c][0] = gap;
        sh[c][0] = 0;
        for (int k = 1; k <= cnt; k++) begin
            sp[c][k] = p;
            sh[c][k] = h;
        end
        nseg[c] = cnt + 1;
        ld_cnt[c]++;
    endtask

    task automatic load_rand(input int c, input int ne, output longint ep, output longint eh);
        ep = 0;
        eh = 0;
        sp[c][0] = $urandom_range(5, 20);
        sh[c][0] = 0;
        for (int k = 1; k <= ne + 1; k++) begin
            sp[c][k] = $urandom_range(2, 30);
            sh[c][k] = $urandom_range(1, sp[c][k] - 1);
            if (k <= ne) begin
                ep += sp[c][k];
                eh += sh[c][k];
            end
        end
        nseg[c] = ne + 2;
        ld_cnt[c]++;
    endtask

    task automatic wait_res(input int cnt, input int budget, input bit rnd);
        int k = 0;
        while (rq.size() < cnt && k < budget) begin
            if (rnd) rif.ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        rif.ready = 1'b1;
        if (rq.size() < cnt) begin
            checks++;
            errors++;
            $display("FAIL wait_res: got %0d results, expected %0d", rq.size(), cnt);
        end
    endtask

    task automatic pop_chk(input string tag, input int ch, input longint per, input longint hi, input int tmo);
        res_t r;
        if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no result, expected ch %0d", tag, ch);
        end else begin
            r = rq.pop_front();
            chk({tag, ".ch"}, r.ch, ch);
            chk({tag, ".period"}, r.per, per);
            chk({tag, ".high"}, r.hi, hi);
            chk({tag, ".timeout"}, r.tmo, tmo);
        end
    endtask

    initial begin
        vec_t   vt [4];
        longint ep [CH];
        longint eh [CH];
        int     nr [CH];
        int     seen;
        res_t   r;

        vt[0] = '{ch: 0, kind: 0, p: 20, h: 5,  n: 100, ep: 2000, eh: 500, et: 0};
        vt[1] = '{ch: 1, kind: 0, p: 37, h: 20, n: 0,   ep: 37,   eh: 20,  et: 0};
        vt[2] = '{ch: 2, kind: 1, p: 0,  h: 0,  n: 7,   ep: 0,    eh: 0,   et: 1};
        vt[3] = '{ch: 3, kind: 2, p: 0,  h: 0,  n: 3,   ep: TO,   eh: TO,  et: 1};

        rst = 1'b1;
        start = '0;
        n_in = '0;
        rif.ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst.valid", rif.valid, 0);
        chk("rst.ch", rif.ch, 0);
        chk("rst.period", rif.period, 0);
        chk("rst.high", rif.high, 0);
        chk("rst.timeout", rif.timeout, 0);
        chk("rst.busy", busy, 0);
        tick();
        rst = 1'b0;
        tick(2);

        // Four channels finish together while the consumer stalls.
        rif.ready = 1'b0;
        for (int c = 0; c < CH; c++) load_seg(c, 5, 10, 5, 5);
        n_in = 16'd4;
        start = 4'hf;
        @(negedge clk);
        chk("A.busy_before", busy, 0);
        tick();
        start = '0;
        @(negedge clk);
        chk("A.busy_after", busy, 4'hf);
        tick(10);
        n_in = 16'd1;
        start = 4'hf;
        tick();
        start = '0;
        tick(55);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("A.stall.valid", rif.valid, 1);
            chk("A.stall.ch", rif.ch, 0);
            chk("A.stall.period", rif.period, 40);
            chk("A.stall.high", rif.high, 20);
            tick(4);
        end
        chk("A.stall.none_taken", rq.size(), 0);
        rif.ready = 1'b1;
        wait_res(4, 20, 1'b0);
        if (rq.size() >= 4)
            for (int k = 0; k < 3; k++) chk("A.consecutive", rq[k + 1].cyc - rq[k].cyc, 1);
        for (int c = 0; c < CH; c++) pop_chk("A.res", c, 40, 20, 0);
        tick(5);

        for (int i = 0; i < 4; i++) begin
            case (vt[i].kind)
                0: load_seg(vt[i].ch, 5, vt[i].p, vt[i].h, ((vt[i].n == 0) ? 1 : vt[i].n) + 1);
                1: load_seg(vt[i].ch, 5, 0, 0, 0);
                default: load_seg(vt[i].ch, 5, TO + 300, TO + 300, 1);
            endcase
            n_in = 16'(vt[i].n);
            start = 4'(1 << vt[i].ch);
            tick();
            start = '0;
            wait_res(1, TO + 600, 1'b0);
            pop_chk($sformatf("T%0d", i), vt[i].ch, vt[i].ep, vt[i].eh, vt[i].et);
            @(negedge clk);
            chk("T.valid_drops", rif.valid, 0);
            tick(5);
        end

        // Reset in the middle of a window.
        load_seg(0, 5, 16, 8, 9);
        n_in = 16'd8;
        start = 4'h1;
        tick();
        start = '0;
        tick(40);
        rst = 1'b1;
        @(negedge clk);
        chk("B.rst_busy", busy, 0);
        chk("B.rst_valid", rif.valid, 0);
        tick(2);
        rst = 1'b0;
        tick(300);
        chk("B.no_stale", rq.size(), 0);
        chk("B.idle_valid", rif.valid, 0);

        // Reset while a result is held on a stalled port.
        rif.ready = 1'b0;
        load_seg(1, 5, 10, 3, 3);
        n_in = 16'd2;
        start = 4'h2;
        tick();
        start = '0;
        tick(60);
        @(negedge clk);
        chk("B.held_valid", rif.valid, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("B.held_cleared", rif.valid, 0);
        tick(2);
        rst = 1'b0;
        rif.ready = 1'b1;
        tick(50);
        chk("B.held_discarded", rq.size(), 0);

        load_seg(0, 5, 16, 8, 9);
        n_in = 16'd8;
        start = 4'h1;
        tick();
        start = '0;
        wait_res(1, 500, 1'b0);
        pop_chk("B.restart", 0, 128, 64, 0);
        tick(5);

        // Random segment lengths, staggered starts, random back-pressure.
        for (int round = 0; round < 6; round++) begin
            for (int c = 0; c < CH; c++) begin
                nr[c] = $urandom_range(0, 6);
                load_rand(c, (nr[c] == 0) ? 1 : nr[c], ep[c], eh[c]);
                n_in = 16'(nr[c]);
                start = 4'(1 << c);
                tick();
                start = '0;
            end
            wait_res(4, 1500, 1'b1);
            seen = 0;
            while (rq.size() > 0) begin
                r = rq.pop_front();
                if (r.ch >= 0 && r.ch < CH) begin
                    chk($sformatf("R%0d.ch%0d.period", round, r.ch), r.per, ep[r.ch]);
                    chk($sformatf("R%0d.ch%0d.high", round, r.ch), r.hi, eh[r.ch]);
                    chk($sformatf("R%0d.ch%0d.timeout", round, r.ch), r.tmo, 0);
                    seen += 1 << r.ch;
                end
            end
            chk($sformatf("R%0d.each_channel_once", round), seen, 4'hf);
            tick(5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
